// File: rtl/cw341_reg_arb_pkg.sv
// Shared types for the CW341 register-bus arbiter: FSM states, the host bus
// bundle carried through the delay pipe, and the pipe depth.
package cw341_reg_arb_pkg;

  localparam int HPIPE_DEPTH = 2;

  // Field widths follow the default 21-bit bus split with a 7-bit byte count.
  localparam int HB_ADDR_W = 14;
  localparam int HB_BCNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [HB_ADDR_W-1:0] address;
    logic [HB_BCNT_W-1:0] bytecnt;
    logic [7:0]           data;
    logic                 read;
    logic                 write;
    logic                 addrvalid;
  } host_bus_t;

  localparam int HB_W = $bits(host_bus_t);

  function automatic logic bus_active(host_bus_t b);
    return b.read | b.write | b.addrvalid;
  endfunction

endpackage

// File: rtl/cw341_reg_arb_hpipe.sv
// Delay pipe for the host register-bus fields; reports which stages carry
// host activity so the arbiter can keep internal slots out of their way.
module cw341_reg_arb_hpipe
  import cw341_reg_arb_pkg::*;
#(
  parameter int pDEPTH = HPIPE_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HB_W-1:0]   bus_i,
  output logic [HB_W-1:0]   stage1_o,
  output logic [pDEPTH-1:0] act_o
);

  host_bus_t stage_q [pDEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < pDEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= host_bus_t'(bus_i);
      for (int i = 1; i < pDEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    act_o = '0;
    for (int i = 0; i < pDEPTH; i++) act_o[i] = bus_active(stage_q[i]);
  end

  assign stage1_o = stage_q[0];

endmodule

// File: rtl/cw341_reg_arb.sv
// Two-master arbiter for the CW341 register bus: the host always wins, the
// internal master gets single-byte slots whenever the delayed host path is quiet.
module cw341_reg_arb
  import cw341_reg_arb_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pMAX_WAIT     = 255
) (
  input  logic                                 usb_clk,
  input  logic                                 rst_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] host_address,
  input  logic [pBYTECNT_SIZE-1:0]             host_bytecnt,
  input  logic [7:0]                           host_datao,
  input  logic                                 host_read,
  input  logic                                 host_write,
  input  logic                                 host_addrvalid,
  output logic [7:0]                           host_datai,
  input  logic                                 int_req,
  input  logic                                 int_we,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] int_address,
  input  logic [pBYTECNT_SIZE-1:0]             int_bytecnt,
  input  logic [7:0]                           int_wdata,
  output logic                                 int_gnt,
  output logic [7:0]                           int_rdata,
  output logic                                 int_rvalid,
  output logic                                 int_timeout,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_datao,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid,
  input  logic [7:0]                           reg_datai
);

  localparam int CNT_W = (pMAX_WAIT < 2) ? 1 : $clog2(pMAX_WAIT);

  host_bus_t              host_in, stage1, bus_d, bus_q;
  logic [HPIPE_DEPTH-1:0] stage_act;
  arb_state_e             state_d, state_q;
  logic                   h_now, h_busy, grant;
  logic                   we_q, gnt_q, rvalid_q, tmo_d, tmo_q;
  logic [7:0]             rdata_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  assign host_in = '{address: host_address, bytecnt: host_bytecnt, data: host_datao,
                     read: host_read, write: host_write, addrvalid: host_addrvalid};

  cw341_reg_arb_hpipe #(
    .pDEPTH (HPIPE_DEPTH)
  ) u_hpipe (
    .clk_i    (usb_clk),
    .rst_ni   (rst_n),
    .bus_i    (host_in),
    .stage1_o (stage1),
    .act_o    (stage_act)
  );

  assign h_now  = host_read | host_write;
  assign h_busy = h_now | (|stage_act);
  assign grant  = (state_q == ST_IDLE) && int_req && !h_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_SLOT;
      ST_SLOT:  state_d = ST_GUARD;
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus register sits level with the second host stage, so a host strobe
  // reaches the bus two cycles after the port; GUARD simply holds the address.
  always_comb begin
    bus_d           = bus_q;
    bus_d.read      = 1'b0;
    bus_d.write     = 1'b0;
    bus_d.addrvalid = 1'b0;
    if (state_d == ST_SLOT) begin
      bus_d.address   = int_address;
      bus_d.bytecnt   = int_bytecnt;
      bus_d.data      = int_wdata;
      bus_d.read      = ~int_we;
      bus_d.write     = int_we;
      bus_d.addrvalid = 1'b1;
    end else if (stage_act[0]) begin
      bus_d = stage1;
    end
  end

  always_comb begin
    cnt_d = '0;
    tmo_d = 1'b0;
    if (int_req && !grant) begin
      if (cnt_q == CNT_W'(pMAX_WAIT - 1)) tmo_d = 1'b1;
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bus_q    <= '0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      gnt_q    <= (state_d == ST_SLOT);
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rvalid_q <= (state_q == ST_GUARD) && !we_q;
      if (grant) we_q <= int_we;
      if ((state_q == ST_GUARD) && !we_q) rdata_q <= reg_datai;
    end
  end

  assign reg_address   = bus_q.address;
  assign reg_bytecnt   = bus_q.bytecnt;
  assign reg_datao     = bus_q.data;
  assign reg_read      = bus_q.read;
  assign reg_write     = bus_q.write;
  assign reg_addrvalid = bus_q.addrvalid;
  assign host_datai    = reg_datai;
  assign int_gnt       = gnt_q;
  assign int_rdata     = rdata_q;
  assign int_rvalid    = rvalid_q;
  assign int_timeout   = tmo_q;

endmodule

// File: tb/tb_cw341_reg_arb.sv
// Self-checking bench for cw341_reg_arb: host vector table, internal read table,
// hand sequences for contention, starvation, reset and back-to-back slots.
module tb_cw341_reg_arb;

  localparam int AW = 14;
  localparam int BW = 7;

  logic          usb_clk, rst_n;
  logic [AW-1:0] host_address, int_address, reg_address;
  logic [BW-1:0] host_bytecnt, int_bytecnt, reg_bytecnt;
  logic [7:0]    host_datao, host_datai, int_wdata, int_rdata, reg_datao, reg_datai;
  logic          host_read, host_write, host_addrvalid;
  logic          int_req, int_we, int_gnt, int_rvalid, int_timeout;
  logic          reg_read, reg_write, reg_addrvalid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bcnt;
    logic [7:0]    data;
  } busExp_t;

  busExp_t    hostBusQ[$];
  busExp_t    intBusQ[$];
  logic [7:0] rdQ[$];

  cw341_reg_arb #(
    .pADDR_WIDTH   (21),
    .pBYTECNT_SIZE (7),
    .pMAX_WAIT     (4)
  ) dut (
    .usb_clk        (usb_clk),
    .rst_n          (rst_n),
    .host_address   (host_address),
    .host_bytecnt   (host_bytecnt),
    .host_datao     (host_datao),
    .host_read      (host_read),
    .host_write     (host_write),
    .host_addrvalid (host_addrvalid),
    .host_datai     (host_datai),
    .int_req        (int_req),
    .int_we         (int_we),
    .int_address    (int_address),
    .int_bytecnt    (int_bytecnt),
    .int_wdata      (int_wdata),
    .int_gnt        (int_gnt),
    .int_rdata      (int_rdata),
    .int_rvalid     (int_rvalid),
    .int_timeout    (int_timeout),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_datai      (reg_datai)
  );

  initial begin
    usb_clk = 1'b0;
    forever #5 usb_clk = ~usb_clk;
  end

  // Read-only register file seen by the arbiter.
  function automatic logic [7:0] regModel(input logic [AW-1:0] a);
    case (a)
      14'h0005: return 8'h3C;
      14'h0007: return 8'h81;
      14'h0009: return 8'h5A;
      default:  return {a[3:0], ~a[3:0]};
    endcase
  endfunction

  assign reg_datai = regModel(reg_address);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an access, expected none", name);
  endtask

  task automatic compareBus(input string name, input busExp_t e);
    checkOutput({name, " read"}, reg_read, e.rd);
    checkOutput({name, " write"}, reg_write, e.wr);
    checkOutput({name, " addrvalid"}, reg_addrvalid, 1);
    checkOutput({name, " address"}, reg_address, e.addr);
    checkOutput({name, " bytecnt"}, reg_bytecnt, e.bcnt);
    checkOutput({name, " datao"}, reg_datao, e.data);
  endtask

  task automatic nextCycle();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                               input logic [BW-1:0] bcnt, input logic [7:0] data);
    busExp_t e;
    host_read      = rd;
    host_write     = wr;
    host_addrvalid = rd | wr;
    host_address   = addr;
    host_bytecnt   = bcnt;
    host_datao     = data;
    if (rd | wr) begin
      e = '{rd: rd, wr: wr, addr: addr, bcnt: bcnt, data: data};
      hostBusQ.push_back(e);
    end
  endtask

  task automatic requestInternal(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] bcnt,
                                 input logic [7:0] wdata, input logic [7:0] expRd, input logic expectRvalid);
    busExp_t e;
    int_req     = 1'b1;
    int_we      = we;
    int_address = addr;
    int_bytecnt = bcnt;
    int_wdata   = wdata;
    e = '{rd: ~we, wr: we, addr: addr, bcnt: bcnt, data: wdata};
    intBusQ.push_back(e);
    if (expectRvalid) rdQ.push_back(expRd);
  endtask

  // Bus scoreboard: every strobe must match the oldest outstanding access of its owner.
  always @(negedge usb_clk) begin
    busExp_t e;
    if (rst_n === 1'b1 && (reg_read === 1'b1 || reg_write === 1'b1)) begin
      if (int_gnt === 1'b1) begin
        if (intBusQ.size() == 0) reportFail("intBus unexpected");
        else begin
          e = intBusQ.pop_front();
          compareBus("intBus", e);
        end
      end else begin
        if (hostBusQ.size() == 0) reportFail("hostBus unexpected");
        else begin
          e = hostBusQ.pop_front();
          compareBus("hostBus", e);
        end
      end
    end
    if (rst_n === 1'b1 && int_rvalid === 1'b1) begin
      if (rdQ.size() == 0) reportFail("rvalid unexpected");
      else checkOutput("rdata scoreboard", int_rdata, rdQ.pop_front());
    end
  end

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bcnt;
    logic [7:0]    data;
    logic          expRead;
    logic          expWrite;
    logic [AW-1:0] expAddr;
    logic [BW-1:0] expBcnt;
    logic [7:0]    expData;
    logic [7:0]    expDatai;
  } hostVec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] bcnt;
    logic [AW-1:0] expAddr;
    logic [BW-1:0] expBcnt;
    logic [7:0]    expRdata;
  } intVec_t;

  initial begin
    hostVec_t hv[4];
    intVec_t  iv[3];

    hv[0] = '{rd: 1, wr: 0, addr: 14'h0009, bcnt: 7'd1,    data: 8'h00, expRead: 1, expWrite: 0,
              expAddr: 14'h0009, expBcnt: 7'd1,    expData: 8'h00, expDatai: 8'h5A};
    hv[1] = '{rd: 0, wr: 1, addr: 14'h0123, bcnt: 7'd4,    data: 8'hC3, expRead: 0, expWrite: 1,
              expAddr: 14'h0123, expBcnt: 7'd4,    expData: 8'hC3, expDatai: 8'h00};
    hv[2] = '{rd: 1, wr: 0, addr: 14'h0007, bcnt: 7'd2,    data: 8'h00, expRead: 1, expWrite: 0,
              expAddr: 14'h0007, expBcnt: 7'd2,    expData: 8'h00, expDatai: 8'h81};
    hv[3] = '{rd: 0, wr: 1, addr: 14'h3FFF, bcnt: 7'h7F,   data: 8'hFF, expRead: 0, expWrite: 1,
              expAddr: 14'h3FFF, expBcnt: 7'h7F,   expData: 8'hFF, expDatai: 8'h00};

    iv[0] = '{addr: 14'h0005, bcnt: 7'd2, expAddr: 14'h0005, expBcnt: 7'd2, expRdata: 8'h3C};
    iv[1] = '{addr: 14'h0007, bcnt: 7'd1, expAddr: 14'h0007, expBcnt: 7'd1, expRdata: 8'h81};
    iv[2] = '{addr: 14'h000F, bcnt: 7'd3, expAddr: 14'h000F, expBcnt: 7'd3, expRdata: 8'hF0};

    rst_n       = 1'b0;
    int_req     = 1'b0;
    int_we      = 1'b0;
    int_address = '0;
    int_bytecnt = '0;
    int_wdata   = '0;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) nextCycle();

    checkOutput("reset reg_address", reg_address, 0);
    checkOutput("reset reg_bytecnt", reg_bytecnt, 0);
    checkOutput("reset reg_datao", reg_datao, 0);
    checkOutput("reset reg_read", reg_read, 0);
    checkOutput("reset reg_write", reg_write, 0);
    checkOutput("reset reg_addrvalid", reg_addrvalid, 0);
    checkOutput("reset int_gnt", int_gnt, 0);
    checkOutput("reset int_rdata", int_rdata, 0);
    checkOutput("reset int_rvalid", int_rvalid, 0);
    checkOutput("reset int_timeout", int_timeout, 0);
    rst_n = 1'b1;
    repeat (2) nextCycle();

    $display("[TB] host vector table");
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (i >= 2) begin
        checkOutput($sformatf("host[%0d] reg_read", i-2), reg_read, hv[i-2].expRead);
        checkOutput($sformatf("host[%0d] reg_write", i-2), reg_write, hv[i-2].expWrite);
        checkOutput($sformatf("host[%0d] reg_address", i-2), reg_address, hv[i-2].expAddr);
        checkOutput($sformatf("host[%0d] reg_bytecnt", i-2), reg_bytecnt, hv[i-2].expBcnt);
        checkOutput($sformatf("host[%0d] reg_datao", i-2), reg_datao, hv[i-2].expData);
        if (hv[i-2].expRead) checkOutput($sformatf("host[%0d] host_datai", i-2), host_datai, hv[i-2].expDatai);
      end
      if (i < 4) applyStimulus(hv[i].rd, hv[i].wr, hv[i].addr, hv[i].bcnt, hv[i].data);
      else       applyStimulus(0, 0, 0, 0, 0);
    end
    nextCycle();
    checkOutput("idle reg_write", reg_write, 0);
    checkOutput("idle reg_addrvalid", reg_addrvalid, 0);
    checkOutput("idle address hold", reg_address, 14'h3FFF);
    checkOutput("idle datao hold", reg_datao, 8'hFF);

    $display("[TB] internal read table");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      requestInternal(0, iv[i].addr, iv[i].bcnt, 8'h00, iv[i].expRdata, 1);
      nextCycle();
      checkOutput($sformatf("iread[%0d] slot int_gnt", i), int_gnt, 1);
      checkOutput($sformatf("iread[%0d] slot reg_read", i), reg_read, 1);
      checkOutput($sformatf("iread[%0d] slot reg_address", i), reg_address, iv[i].expAddr);
      checkOutput($sformatf("iread[%0d] slot reg_bytecnt", i), reg_bytecnt, iv[i].expBcnt);
      int_req = 1'b0;
      nextCycle();
      checkOutput($sformatf("iread[%0d] guard int_gnt", i), int_gnt, 0);
      checkOutput($sformatf("iread[%0d] guard reg_read", i), reg_read, 0);
      checkOutput($sformatf("iread[%0d] guard reg_address", i), reg_address, iv[i].expAddr);
      checkOutput($sformatf("iread[%0d] guard int_rvalid", i), int_rvalid, 0);
      nextCycle();
      checkOutput($sformatf("iread[%0d] int_rvalid", i), int_rvalid, 1);
      checkOutput($sformatf("iread[%0d] int_rdata", i), int_rdata, iv[i].expRdata);
      nextCycle();
      checkOutput($sformatf("iread[%0d] rvalid pulse", i), int_rvalid, 0);
    end

    $display("[TB] simultaneous host write and internal request");
    nextCycle();
    applyStimulus(0, 1, 14'h0010, 7'd1, 8'hA5);
    requestInternal(1, 14'h0020, 7'd1, 8'h77, 8'h00, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("simul t+1 int_gnt", int_gnt, 0);
    nextCycle();
    checkOutput("simul t+2 reg_write", reg_write, 1);
    checkOutput("simul t+2 reg_datao", reg_datao, 8'hA5);
    checkOutput("simul t+2 int_gnt", int_gnt, 0);
    nextCycle();
    checkOutput("simul t+3 reg_write", reg_write, 0);
    checkOutput("simul t+3 int_gnt", int_gnt, 0);
    nextCycle();
    checkOutput("simul t+4 int_gnt", int_gnt, 1);
    checkOutput("simul t+4 reg_datao", reg_datao, 8'h77);
    checkOutput("simul t+4 reg_address", reg_address, 14'h0020);
    int_req = 1'b0;
    repeat (3) nextCycle();

    $display("[TB] host read during internal read");
    nextCycle();
    requestInternal(0, 14'h0007, 7'd1, 8'h00, 8'h81, 1);
    nextCycle();
    checkOutput("hdur t+1 int_gnt", int_gnt, 1);
    int_req = 1'b0;
    applyStimulus(1, 0, 14'h0009, 7'd2, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hdur t+2 reg_read", reg_read, 0);
    checkOutput("hdur t+2 reg_address", reg_address, 14'h0007);
    nextCycle();
    checkOutput("hdur t+3 reg_read", reg_read, 1);
    checkOutput("hdur t+3 reg_address", reg_address, 14'h0009);
    checkOutput("hdur t+3 host_datai", host_datai, 8'h5A);
    checkOutput("hdur t+3 int_rvalid", int_rvalid, 1);
    checkOutput("hdur t+3 int_rdata", int_rdata, 8'h81);
    repeat (2) nextCycle();

    $display("[TB] back-to-back internal writes");
    nextCycle();
    requestInternal(1, 14'h0030, 7'd1, 8'h11, 8'h00, 0);
    nextCycle();
    checkOutput("b2b t+1 reg_write", reg_write, 1);
    checkOutput("b2b t+1 reg_datao", reg_datao, 8'h11);
    requestInternal(1, 14'h0031, 7'd1, 8'h22, 8'h00, 0);
    nextCycle();
    checkOutput("b2b t+2 reg_write", reg_write, 0);
    nextCycle();
    checkOutput("b2b t+3 reg_write", reg_write, 0);
    checkOutput("b2b t+3 int_rvalid", int_rvalid, 0);
    nextCycle();
    checkOutput("b2b t+4 reg_write", reg_write, 1);
    checkOutput("b2b t+4 reg_datao", reg_datao, 8'h22);
    checkOutput("b2b t+4 int_gnt", int_gnt, 1);
    int_req = 1'b0;
    repeat (3) nextCycle();

    $display("[TB] starvation under continuous host traffic");
    nextCycle();
    applyStimulus(1, 0, 14'h0003, 7'd1, 8'h00);
    requestInternal(0, 14'h0004, 7'd1, 8'h00, 8'h4B, 1);
    for (int k = 1; k <= 12; k++) begin
      nextCycle();
      checkOutput($sformatf("starve k=%0d int_timeout", k), int_timeout, (k % 4 == 0));
      applyStimulus(1, 0, 14'h0003, 7'd1, 8'h00);
    end
    nextCycle();
    checkOutput("starve k=13 int_timeout", int_timeout, 0);
    applyStimulus(0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("starve h+1 int_gnt", int_gnt, 0);
    nextCycle();
    checkOutput("starve h+2 int_gnt", int_gnt, 0);
    nextCycle();
    checkOutput("starve h+3 int_gnt", int_gnt, 1);
    checkOutput("starve h+3 reg_address", reg_address, 14'h0004);
    checkOutput("starve h+3 int_timeout", int_timeout, 0);
    int_req = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("starve h+5 int_rvalid", int_rvalid, 1);
    checkOutput("starve h+5 int_rdata", int_rdata, 8'h4B);
    repeat (2) nextCycle();

    $display("[TB] reset during guard of a read");
    nextCycle();
    requestInternal(0, 14'h0005, 7'd2, 8'h00, 8'h00, 0);
    nextCycle();
    checkOutput("rstmid t+1 int_gnt", int_gnt, 1);
    int_req = 1'b0;
    nextCycle();
    rst_n = 1'b0;
    nextCycle();
    checkOutput("rstmid reg_address", reg_address, 0);
    checkOutput("rstmid reg_bytecnt", reg_bytecnt, 0);
    checkOutput("rstmid reg_datao", reg_datao, 0);
    checkOutput("rstmid reg_read", reg_read, 0);
    checkOutput("rstmid reg_addrvalid", reg_addrvalid, 0);
    checkOutput("rstmid int_gnt", int_gnt, 0);
    checkOutput("rstmid int_rdata", int_rdata, 0);
    checkOutput("rstmid int_rvalid", int_rvalid, 0);
    checkOutput("rstmid int_timeout", int_timeout, 0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rstmid t+4 int_rvalid", int_rvalid, 0);
    nextCycle();
    checkOutput("rstmid t+5 int_rvalid", int_rvalid, 0);

    nextCycle();
    requestInternal(0, 14'h0009, 7'd1, 8'h00, 8'h5A, 1);
    nextCycle();
    int_req = 1'b0;
    repeat (4) nextCycle();

    checkOutput("hostBusQ drained", hostBusQ.size(), 0);
    checkOutput("intBusQ drained", intBusQ.size(), 0);
    checkOutput("rdQ drained", rdQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
